// File: rtl/cam_ctrl_pkg.sv
// ============================================================================
// Module  : cam_ctrl_pkg
// Brief   : Command encodings and FSM state type for the CAM controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_ctrl_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WRITE       = 3'd1,
    S_SRCH_DRIVE  = 3'd2,
    S_SRCH_SAMPLE = 3'd3,
    S_RESP        = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cam_prio_enc.sv
// ============================================================================
// Module  : cam_prio_enc
// Brief   : Combinational lowest-index priority encoder with multi-hit flag.
//           Count output present when CAM_CTRL_MATCH_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_prio_enc #(
  parameter int CAM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic [CAM_DEPTH-1:0]          i_match,
  output logic                          o_hit,
  output logic [ADDR_W-1:0]             o_addr,
  output logic                          o_multi
`ifdef CAM_CTRL_MATCH_COUNT_EN
  ,
  output logic [$clog2(CAM_DEPTH+1)-1:0] o_count
`endif
);

  localparam int CNT_W = $clog2(CAM_DEPTH + 1);

  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_addr;

  // Scanning downward leaves the lowest set index in w_addr.
  always_comb begin
    w_count = '0;
    w_addr  = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (i_match[i]) begin
        w_addr = ADDR_W'(i);
      end
      w_count = w_count + CNT_W'(i_match[i]);
    end
  end

  assign o_hit   = |i_match;
  assign o_addr  = w_addr;
  assign o_multi = (w_count > CNT_W'(1));

`ifdef CAM_CTRL_MATCH_COUNT_EN
  assign o_count = w_count;
`endif

endmodule

`default_nettype wire

// File: rtl/cam_ctrl.sv
// ============================================================================
// Module  : cam_ctrl
// Brief   : Ternary CAM sequencer: write/invalidate/search commands, row valid
//           tracking and priority-encoded search response.
//           Optional macro CAM_CTRL_MATCH_COUNT_EN adds o_rsp_count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_ctrl #(
  parameter int CAM_WIDTH = 8,
  parameter int CAM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  input  logic [CAM_WIDTH-1:0]   i_cmd_word,
  input  logic [CAM_WIDTH-1:0]   i_cmd_mask,
  output logic [CAM_WIDTH-1:0]   o_cam_search_word,
  output logic [CAM_WIDTH-1:0]   o_cam_dont_care_mask,
  output logic [CAM_DEPTH-1:0]   o_cam_we,
  input  logic [CAM_DEPTH-1:0]   i_cam_row_match,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic                   o_rsp_hit,
  output logic [ADDR_W-1:0]      o_rsp_addr,
  output logic                   o_rsp_multi
`ifdef CAM_CTRL_MATCH_COUNT_EN
  ,
  output logic [$clog2(CAM_DEPTH+1)-1:0] o_rsp_count
`endif
);

  import cam_ctrl_pkg::*;

  localparam int CNT_W = $clog2(CAM_DEPTH + 1);

  state_t                 r_state;
  logic                   r_cmd_ready;
  logic [CAM_DEPTH-1:0]   r_valid;
  logic [CAM_DEPTH-1:0]   r_we;
  logic [CAM_WIDTH-1:0]   r_search_word;
  logic [CAM_WIDTH-1:0]   r_mask;
  logic                   r_rsp_valid;
  logic                   r_rsp_hit;
  logic [ADDR_W-1:0]      r_rsp_addr;
  logic                   r_rsp_multi;

  logic                   w_cmd_fire;
  logic [CAM_DEPTH-1:0]   w_row_sel;
  logic [CAM_DEPTH-1:0]   w_valid_match;
  logic                   w_hit;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_multi;

  assign w_cmd_fire    = i_cmd_valid && r_cmd_ready;
  assign w_valid_match = i_cam_row_match & r_valid;

  // An out-of-range address decodes to all zeros, so such commands fall away.
  always_comb begin
    w_row_sel = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      w_row_sel[i] = (i_cmd_addr == ADDR_W'(i));
    end
  end

`ifdef CAM_CTRL_MATCH_COUNT_EN
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] r_rsp_count;

  cam_prio_enc #(
    .CAM_DEPTH (CAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_prio_enc (
    .i_match (w_valid_match),
    .o_hit   (w_hit),
    .o_addr  (w_addr),
    .o_multi (w_multi),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_count <= '0;
    end else if (r_state == S_SRCH_SAMPLE) begin
      r_rsp_count <= w_count;
    end
  end

  assign o_rsp_count = r_rsp_count;
`else
  cam_prio_enc #(
    .CAM_DEPTH (CAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_prio_enc (
    .i_match (w_valid_match),
    .o_hit   (w_hit),
    .o_addr  (w_addr),
    .o_multi (w_multi)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_valid       <= '0;
      r_we          <= '0;
      r_search_word <= '0;
      r_mask        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_addr    <= '0;
      r_rsp_multi   <= 1'b0;
    end else begin
      r_we <= '0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            case (i_cmd_op)
              OP_WRITE: begin
                r_search_word <= i_cmd_word;
                r_mask        <= i_cmd_mask;
                r_we          <= w_row_sel;
                r_cmd_ready   <= 1'b0;
                r_state       <= S_WRITE;
              end
              OP_SEARCH: begin
                r_search_word <= i_cmd_word;
                r_mask        <= i_cmd_mask;
                r_cmd_ready   <= 1'b0;
                r_state       <= S_SRCH_DRIVE;
              end
              OP_INV: begin
                r_valid <= r_valid & ~w_row_sel;
              end
              default: begin
              end
            endcase
          end
        end
        S_WRITE: begin
          // r_we is the one-hot of the row being written (zero if dropped).
          r_valid     <= r_valid | r_we;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_SRCH_DRIVE: begin
          r_state <= S_SRCH_SAMPLE;
        end
        S_SRCH_SAMPLE: begin
          r_rsp_hit   <= w_hit;
          r_rsp_addr  <= w_addr;
          r_rsp_multi <= w_multi;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready          = r_cmd_ready;
  assign o_cam_search_word    = r_search_word;
  assign o_cam_dont_care_mask = r_mask;
  assign o_cam_we             = r_we;
  assign o_rsp_valid          = r_rsp_valid;
  assign o_rsp_hit            = r_rsp_hit;
  assign o_rsp_addr           = r_rsp_addr;
  assign o_rsp_multi          = r_rsp_multi;

endmodule

`default_nettype wire
